spi_master: RTL and testbench



---
 rtl/spi_master.sv | 140 ++++++++++++++
 tb/tb_spi_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one 16-bit full-duplex frame per valid/ready request.
// The chip-select timing around each frame and the sck rate are set by parameters.
module spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);
    localparam int unsigned HW   = $clog2(CLK_DIV + 1);
    localparam int unsigned TMAX = (CS_SETUP > CS_HOLD)
                                   ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                   : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tmr;
    logic [HW-1:0] hcnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   tx_shift;
    logic [15:0]   rx_shift;
    logic          tmr_done;
    logic          half_done;
    logic          last_fall;
    logic          cs_n_d;
    logic          tx_ready_d;
    logic          rx_valid_d;
    logic          sck_d;

    assign tmr_done  = (tmr == '0);
    assign half_done = (hcnt == '0);
    assign last_fall = (state == XFER) && half_done && sck && (bit_cnt == 4'd0);
    assign mosi      = tx_shift[15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_valid && tx_ready) state_next = SETUP;
            SETUP:   if (tmr_done) state_next = XFER;
            XFER:    if (last_fall) state_next = HOLD;
            HOLD:    if (tmr_done) state_next = GAP;
            GAP:     if (tmr_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they change on
    // the same edge as the state register.
    always_comb begin
        cs_n_d     = 1'b1;
        tx_ready_d = 1'b0;
        sck_d      = 1'b0;
        case (state_next)
            SETUP, XFER, HOLD: cs_n_d     = 1'b0;
            IDLE:              tx_ready_d = 1'b1;
            default:           ;
        endcase
        rx_valid_d = (state == HOLD) && (state_next == GAP);
        if (state == XFER && !last_fall) begin
            sck_d = half_done ? ~sck : sck;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr      <= '0;
            hcnt     <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b1;
            cs_n     <= 1'b1;
            sck      <= 1'b0;
        end else begin
            tx_ready <= tx_ready_d;
            cs_n     <= cs_n_d;
            sck      <= sck_d;
            rx_valid <= rx_valid_d;
            if (rx_valid_d) begin
                rx_data <= rx_shift;
            end

            if (state_next != state) begin
                case (state_next)
                    SETUP:   tmr <= TW'(CS_SETUP - 1);
                    HOLD:    tmr <= TW'(CS_HOLD - 1);
                    GAP:     tmr <= TW'(CS_GAP - 1);
                    default: tmr <= '0;
                endcase
            end else if (!tmr_done) begin
                tmr <= tmr - TW'(1);
            end

            if (state == IDLE && state_next == SETUP) begin
                tx_shift <= tx_data;
            end

            if (state == SETUP && state_next == XFER) begin
                hcnt    <= HW'(CLK_DIV - 1);
                bit_cnt <= 4'd15;
            end else if (state == XFER) begin
                if (half_done) begin
                    hcnt <= HW'(CLK_DIV - 1);
                    if (!sck) begin
                        rx_shift <= {rx_shift[14:0], miso};
                    end else if (bit_cnt != 4'd0) begin
                        bit_cnt  <= bit_cnt - 4'd1;
                        tx_shift <= {tx_shift[14:0], 1'b0};
                    end
                end else begin
                    hcnt <= hcnt - HW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default-timing instance plus a CLK_DIV=1 instance,
// each driven by a mode-0 slave model.
module tb_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, sck, cs_n, mosi, miso;
    logic [15:0] b_tx_data, b_rx_data;
    logic        b_tx_valid, b_tx_ready, b_rx_valid, b_sck, b_cs_n, b_mosi, b_miso;

    spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_fast (
        .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .sck(b_sck), .cs_n(b_cs_n), .mosi(b_mosi),
        .miso(b_miso)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave models: load word on cs_n fall, shift out on sck fall, capture mosi on sck rise.
    logic [15:0] s_word = '0, s_shift = '0, mosi_cap = '0;
    logic [15:0] b_s_word = '0, b_s_shift = '0, b_mosi_cap = '0;
    int sck_rises = 0, b_rises = 0, rxv_cnt = 0, cs_falls = 0, sck_bad = 0, b_sck_bad = 0;

    always @(negedge cs_n) begin s_shift = s_word; miso = s_word[15]; cs_falls++; end
    always @(negedge sck) if (!cs_n) begin s_shift = s_shift << 1; miso = s_shift[15]; end
    always @(posedge sck) begin mosi_cap = {mosi_cap[14:0], mosi}; sck_rises++; end
    always @(negedge b_cs_n) begin b_s_shift = b_s_word; b_miso = b_s_word[15]; end
    always @(negedge b_sck) if (!b_cs_n) begin b_s_shift = b_s_shift << 1; b_miso = b_s_shift[15]; end
    always @(posedge b_sck) begin b_mosi_cap = {b_mosi_cap[14:0], b_mosi}; b_rises++; end
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt++;
        if (cs_n === 1'b1 && sck === 1'b1) sck_bad++;
        if (b_cs_n === 1'b1 && b_sck === 1'b1) b_sck_bad++;
    end

    typedef struct {
        logic [15:0] tx;
        logic [15:0] slave;
        logic [15:0] exp_rx;
        logic [15:0] exp_mosi;
    } vec_t;

    // One frame on the default instance; a tx_valid pulse is injected at cycle poke_at.
    task automatic run_frame(input vec_t v, input int poke_at, input string tag);
        int lat, first_rise, g, r0, rxv0;
        bit got;
        @(negedge clk);
        check({tag, "_ready"}, tx_ready, 1);
        s_word = v.slave; mosi_cap = '0; r0 = sck_rises; rxv0 = rxv_cnt;
        tx_data = v.tx; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        lat = 1; first_rise = 0; got = 0;
        check({tag, "_cs_low"}, cs_n, 0);
        while (lat < 300) begin
            if (sck && first_rise == 0) first_rise = lat;
            if (rx_valid) begin got = 1; break; end
            if (lat == poke_at) begin tx_data = 16'hFFFF; tx_valid = 1'b1; end
            else if (lat == poke_at + 1) tx_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_rxv_seen"}, got, 1);
        check({tag, "_latency"}, lat, 133);
        check({tag, "_first_rise"}, first_rise, 7);
        check({tag, "_rx_data"}, rx_data, v.exp_rx);
        check({tag, "_cs_high_at_rxv"}, cs_n, 1);
        check({tag, "_mosi"}, mosi_cap, v.exp_mosi);
        check({tag, "_rises"}, sck_rises - r0, 16);
        g = 0;
        while (!tx_ready && g < 50) begin @(negedge clk); g++; end
        check({tag, "_ready_gap"}, g, 4);
        check({tag, "_rxv_pulses"}, rxv_cnt - rxv0, 1);
    endtask

    vec_t vecs[4];

    initial begin
        int n, k, hi, r0, rxv0, lat, first, last, bad_sck, bad_cs, bad_rdy, bad_rxv, bad_mosi, bad_rxd;
        bit seen_low, got;

        vecs[0] = '{tx: 16'hA5C3, slave: 16'h3C5A, exp_rx: 16'h3C5A, exp_mosi: 16'hA5C3};
        vecs[1] = '{tx: 16'hFFFF, slave: 16'h0000, exp_rx: 16'h0000, exp_mosi: 16'hFFFF};
        vecs[2] = '{tx: 16'h0001, slave: 16'h8000, exp_rx: 16'h8000, exp_mosi: 16'h0001};
        vecs[3] = '{tx: 16'h1234, slave: 16'hFEDC, exp_rx: 16'hFEDC, exp_mosi: 16'h1234};

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; miso = 1'b0;
        b_tx_valid = 1'b0; b_tx_data = '0; b_miso = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        bad_sck = 0; bad_cs = 0; bad_rdy = 0; bad_rxv = 0; bad_mosi = 0; bad_rxd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sck !== 1'b0) bad_sck++;
            if (cs_n !== 1'b1) bad_cs++;
            if (tx_ready !== 1'b1) bad_rdy++;
            if (rx_valid !== 1'b0) bad_rxv++;
            if (mosi !== 1'b0) bad_mosi++;
            if (rx_data !== 16'h0000) bad_rxd++;
        end
        check("idle_sck", bad_sck, 0);
        check("idle_cs_n", bad_cs, 0);
        check("idle_tx_ready", bad_rdy, 0);
        check("idle_rx_valid", bad_rxv, 0);
        check("idle_mosi", bad_mosi, 0);
        check("idle_rx_data", bad_rxd, 0);
        check("idle_no_rises", sck_rises, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], -1, $sformatf("v%0d", i));

        // Back-to-back frames with tx_valid held high
        @(negedge clk);
        s_word = 16'h0F0F; mosi_cap = '0; rxv0 = rxv_cnt;
        tx_data = 16'hFFFF; tx_valid = 1'b1;
        n = 0;
        while (cs_n && n < 20) begin @(negedge clk); n++; end
        tx_data = 16'h0001;
        n = 0;
        while (!rx_valid && n < 300) begin @(negedge clk); n++; end
        check("b2b_rx1", rx_data, 16'h0F0F);
        check("b2b_mosi1", mosi_cap, 16'hFFFF);
        s_word = 16'hC0DE; mosi_cap = '0;
        hi = 1; k = 0; seen_low = 0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (!cs_n) begin seen_low = 1; tx_valid = 1'b0; end
            else if (!seen_low) hi++;
            if (rx_valid) break;
        end
        check("b2b_cs_gap", hi, 5);
        check("b2b_period", k, 137);
        check("b2b_rx2", rx_data, 16'hC0DE);
        check("b2b_mosi2", mosi_cap, 16'h0001);
        n = 0;
        while (!tx_ready && n < 50) begin @(negedge clk); n++; end
        check("b2b_rxv_pulses", rxv_cnt - rxv0, 2);

        // Reset during bit 7
        @(negedge clk);
        s_word = 16'h5555; rxv0 = rxv_cnt;
        tx_data = 16'hA5C3; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        r0 = sck_rises; n = 0;
        while (sck_rises - r0 < 9 && n < 300) begin @(negedge clk); n++; end
        check("rst_reached_bit7", sck_rises - r0, 9);
        rst = 1'b1;
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_sck", sck, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_mosi", mosi, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (160) @(negedge clk);
        check("rst_no_rxv", rxv_cnt - rxv0, 0);
        run_frame(vecs[0], -1, "after_rst");

        // tx_valid pulse mid-frame is ignored
        run_frame(vecs[3], 40, "poke");
        n = cs_falls;
        repeat (200) @(negedge clk);
        check("poke_no_extra_frame", cs_falls - n, 0);

        // CLK_DIV=1 instance
        @(negedge clk);
        b_s_word = 16'h96F0; b_mosi_cap = '0; r0 = b_rises;
        b_tx_data = 16'hC3A5; b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        lat = 1; first = 0; last = 0; got = 0;
        while (lat < 100) begin
            if (b_sck) begin if (first == 0) first = lat; last = lat; end
            if (b_rx_valid) begin got = 1; break; end
            @(negedge clk);
            lat++;
        end
        check("fast_rxv_seen", got, 1);
        check("fast_latency", lat, 35);
        check("fast_first_rise", first, 3);
        check("fast_rise_span", last - first, 30);
        check("fast_rises", b_rises - r0, 16);
        check("fast_rx_data", b_rx_data, 16'h96F0);
        check("fast_mosi", b_mosi_cap, 16'hC3A5);

        check("sck_while_cs_high", sck_bad, 0);
        check("fast_sck_while_cs_high", b_sck_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
